// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock through a
// full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sr;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d, bout, accept, last;

    assign d      = sa[0] ^ sb[0] ^ bin;
    assign bout   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            bin <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {d, sr[WIDTH-1:1]};
            bin <= bout;
            cnt <= cnt + CW'(1);
            // Final bit is folded in directly so diff is complete on DONE entry.
            if (last) begin
                diff   <= {d, sr[WIDTH-1:1]};
                borrow <= bout;
            end
        end
    end

endmodule
